spi_transaction_fsm: RTL and testbench
======================================

// Module: spi_transaction_fsm
// PURPOSE
//  Transaction sequencer for the SPI memory slave. Consumes the conditioned chip
//  select and the sclk edge pulses produced by the input conditioners, then
//  drives the write enables for the address latch, data memory and shift register,
//  and the MISO tri-state enable. One instance sits between the conditioners and
//  the shift-register/data-memory datapath.
// PARAMETERS
//  FRAME_BITS   8   sclk edges per frame (7 address bits + R/W bit; also data width)
//  CNT_W        4   counter width; must hold FRAME_BITS
// PORTS
//  clk          in   1      system clock (50 MHz)
//  reset        in   1      asynchronous, active-high reset
//  cs           in   1      conditioned chip select, active low
//  sclk_pe      in   1      one-cycle pulse, conditioned sclk rising edge
//  sclk_ne      in   1      one-cycle pulse, conditioned sclk falling edge
//  rw_bit       in   1      shift register bit 0 after address frame (1=read, 0=write)
//  addr_we      out  1      address latch write enable, one cycle
//  dm_we        out  1      data memory write enable, one cycle
//  sr_we        out  1      shift register parallel-load enable, one cycle
//  miso_bufe    out  1      MISO buffer enable
//  state        out  3      current state code (debug)
// BEHAVIOUR
//  - Registered state + CNT_W-bit edge counter. Outputs are Moore-decoded from state only.
//  - Reset asserted: state=IDLE(0), count=0, all enables 0, immediately (async), any cycle.
//  - cs=1 sampled in any state other than IDLE: next state IDLE, count=0.
//    Takes priority over every edge pulse in the same cycle.
//  - States / codes / transitions:
//    IDLE(0)      cs=0 -> GET_ADDR, count=0.
//    GET_ADDR(1)  sclk_pe: count+1. sclk_pe with count=FRAME_BITS-1 -> GOT_ADDR, count=0.
//    GOT_ADDR(2)  addr_we=1 for exactly 1 cycle.
//                 rw_bit=1 -> READ_LOAD; rw_bit=0 -> WRITE_GET.
//    READ_LOAD(3) sr_we=1 for exactly 1 cycle -> READ_SHIFT.
//    READ_SHIFT(4) miso_bufe=1. sclk_ne: count+1.
//                 sclk_ne with count=FRAME_BITS-1 -> DONE, count=0.
//    WRITE_GET(5) sclk_pe: count+1. sclk_pe with count=FRAME_BITS-1 -> WRITE_STORE, count=0.
//    WRITE_STORE(6) dm_we=1 for exactly 1 cycle -> DONE.
//    DONE(7)      all enables 0. Edge pulses ignored. Wait for cs=1 -> IDLE.
//  - Counted edge only: sclk_ne is ignored in GET_ADDR and WRITE_GET; sclk_pe is
//    ignored in READ_SHIFT. If both pulses arrive in one cycle, only the counted one
//    acts. Edge pulses in IDLE/GOT_ADDR/READ_LOAD/WRITE_STORE/DONE are ignored.
//  - Latency: addr_we and dm_we assert on the cycle after the 8th counted sclk_pe
//    is sampled. sr_we asserts 1 cycle after addr_we. miso_bufe drops on the cycle
//    after the 8th sclk_ne is sampled.
//  - Counter never exceeds FRAME_BITS-1 and cannot wrap. It is cleared on every
//    frame completion and on every abort.
//  - At most one of addr_we/dm_we/sr_we is high in any cycle. miso_bufe=1 only in READ_SHIFT.
//  - Abort mid-frame (cs=1) raises no enable. The next cs=0 starts a clean address frame.
// TESTING
//  1. reset=1 pulse in READ_SHIFT, between clk edges -> state=0 and miso_bufe=0
//     before the next clk edge. count restarts at 0.
//  2. Write: cs=0, 8 sclk_pe with rw_bit=0 -> addr_we=1 for 1 cycle.
//     8 more sclk_pe -> dm_we=1 for 1 cycle, state=7. sr_we and miso_bufe stay 0.
//     cs=1 -> state=0.
//  3. Read: cs=0, 8 sclk_pe with rw_bit=1 -> addr_we cycle N, sr_we cycle N+1,
//     miso_bufe=1 from N+2. miso_bufe=0 the cycle after the 8th sclk_ne.
//  4. Abort: cs=0, 4 sclk_pe, cs=1 -> state=0, no enable pulsed.
//     New cs=0 + 8 sclk_pe -> addr_we after exactly 8 (not 4).
//  5. Ignored edges: sclk_pe/ne while cs=1 -> state stays 0. 3 sclk_pe during
//     READ_SHIFT -> count unchanged. sclk_pe+ne together in GET_ADDR -> count +1 only.
//  6. DONE hold: 10 extra sclk_pe/ne with cs=0 -> state=7, all enables 0 throughout.

Source files
------------

// File: rtl/spi_transaction_fsm.sv
// Transaction sequencer for the SPI memory slave: counts conditioned sclk edges per frame
// and issues the one-cycle write enables and the MISO buffer enable for the datapath.
module spi_transaction_fsm #(
  parameter int FRAME_BITS = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk_pe,
  input  logic       sclk_ne,
  input  logic       rw_bit,
  output logic       addr_we,
  output logic       dm_we,
  output logic       sr_we,
  output logic       miso_bufe,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    st_idle        = 3'd0,
    st_get_addr    = 3'd1,
    st_got_addr    = 3'd2,
    st_read_load   = 3'd3,
    st_read_shift  = 3'd4,
    st_write_get   = 3'd5,
    st_write_store = 3'd6,
    st_done        = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] last_count = CNT_W'(FRAME_BITS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= st_idle;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Deasserted chip select aborts from any active state and beats every edge pulse.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (cs && (state_reg != st_idle)) begin
      state_next = st_idle;
      count_next = '0;
    end else begin
      case (state_reg)
        st_idle: begin
          if (!cs) begin
            state_next = st_get_addr;
            count_next = '0;
          end
        end
        st_get_addr: begin
          if (sclk_pe) begin
            if (count_reg == last_count) begin
              state_next = st_got_addr;
              count_next = '0;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end
        end
        st_got_addr:    state_next = rw_bit ? st_read_load : st_write_get;
        st_read_load:   state_next = st_read_shift;
        st_read_shift: begin
          if (sclk_ne) begin
            if (count_reg == last_count) begin
              state_next = st_done;
              count_next = '0;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end
        end
        st_write_get: begin
          if (sclk_pe) begin
            if (count_reg == last_count) begin
              state_next = st_write_store;
              count_next = '0;
            end else begin
              count_next = count_reg + 1'b1;
            end
          end
        end
        st_write_store: state_next = st_done;
        st_done:        state_next = st_done;
        default: begin
          state_next = st_idle;
          count_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    addr_we   = 1'b0;
    dm_we     = 1'b0;
    sr_we     = 1'b0;
    miso_bufe = 1'b0;
    case (state_reg)
      st_got_addr:    addr_we   = 1'b1;
      st_write_store: dm_we     = 1'b1;
      st_read_load:   sr_we     = 1'b1;
      st_read_shift:  miso_bufe = 1'b1;
      default: ;
    endcase
  end

  assign state = state_reg;

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Directed bench for spi_transaction_fsm: write, read, abort, ignored edges, async reset, DONE hold.
module tb_spi_transaction_fsm;

  logic       clk, reset, cs, sclk_pe, sclk_ne, rw_bit;
  logic       addr_we, dm_we, sr_we, miso_bufe;
  logic [2:0] state;

  int compared   = 0;
  int mismatched = 0;

  spi_transaction_fsm #(.FRAME_BITS(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk_pe(sclk_pe), .sclk_ne(sclk_ne),
    .rw_bit(rw_bit), .addr_we(addr_we), .dm_we(dm_we), .sr_we(sr_we),
    .miso_bufe(miso_bufe), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // enable vector order: {addr_we, dm_we, sr_we, miso_bufe}
  task automatic check(input string tag, input logic [2:0] exp_state, input logic [3:0] exp_en);
    logic [3:0] en;
    en = {addr_we, dm_we, sr_we, miso_bufe};
    compared++;
    assert ({state, en} === {exp_state, exp_en}) else begin
      mismatched++;
      $error("FAIL %s: observed state=%0d en=%b expected state=%0d en=%b",
             tag, state, en, exp_state, exp_en);
    end
    $display("check %-12s state=%0d en=%b", tag, state, en);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic pe, input logic ne);
    sclk_pe = pe;
    sclk_ne = ne;
    step();
    sclk_pe = 1'b0;
    sclk_ne = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; sclk_pe = 1'b0; sclk_ne = 1'b0; rw_bit = 1'b0;
    step(); step();
    check("reset", 3'd0, 4'b0000);
    reset = 1'b0;
    step();
    check("idle", 3'd0, 4'b0000);

    // write transaction
    cs = 1'b0; rw_bit = 1'b0;
    step();
    check("w_start", 3'd1, 4'b0000);
    for (int i = 0; i < 7; i++) begin pulse(1'b1, 1'b0); check("w_addr_bit", 3'd1, 4'b0000); end
    pulse(1'b1, 1'b0);
    check("w_addr_we", 3'd2, 4'b1000);
    step();
    check("w_get", 3'd5, 4'b0000);
    for (int i = 0; i < 7; i++) begin pulse(1'b1, 1'b0); check("w_data_bit", 3'd5, 4'b0000); end
    pulse(1'b1, 1'b0);
    check("w_dm_we", 3'd6, 4'b0100);
    step();
    check("w_done", 3'd7, 4'b0000);
    cs = 1'b1;
    step();
    check("w_end", 3'd0, 4'b0000);

    // read transaction with ignored sclk_pe mid-shift
    cs = 1'b0; rw_bit = 1'b1;
    step();
    check("r_start", 3'd1, 4'b0000);
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0);
    check("r_addr_7", 3'd1, 4'b0000);
    pulse(1'b1, 1'b0);
    check("r_addr_we", 3'd2, 4'b1000);
    step();
    check("r_sr_we", 3'd3, 4'b0010);
    step();
    check("r_shift", 3'd4, 4'b0001);
    for (int i = 0; i < 3; i++) begin pulse(1'b0, 1'b1); check("r_ne", 3'd4, 4'b0001); end
    for (int i = 0; i < 3; i++) begin pulse(1'b1, 1'b0); check("r_pe_ign", 3'd4, 4'b0001); end
    for (int i = 0; i < 4; i++) begin pulse(1'b0, 1'b1); check("r_ne", 3'd4, 4'b0001); end
    pulse(1'b0, 1'b1);
    check("r_done", 3'd7, 4'b0000);
    cs = 1'b1;
    step();
    check("r_end", 3'd0, 4'b0000);

    // asynchronous reset in READ_SHIFT, between clock edges
    cs = 1'b0;
    step();
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
    step(); step();
    check("rst_pre", 3'd4, 4'b0001);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    #1 reset = 1'b1;
    #1 check("rst_async", 3'd0, 4'b0000);
    #1 reset = 1'b0;
    step();
    check("rst_restart", 3'd1, 4'b0000);
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0);
    check("rst_cnt_7", 3'd1, 4'b0000);
    pulse(1'b1, 1'b0);
    check("rst_cnt_8", 3'd2, 4'b1000);
    cs = 1'b1;
    step();
    check("rst_end", 3'd0, 4'b0000);

    // abort mid address frame, then a clean frame
    cs = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin pulse(1'b1, 1'b0); check("ab_bit", 3'd1, 4'b0000); end
    cs = 1'b1;
    step();
    check("ab_idle", 3'd0, 4'b0000);
    cs = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin pulse(1'b1, 1'b0); check("ab_new_bit", 3'd1, 4'b0000); end
    pulse(1'b1, 1'b0);
    check("ab_addr_we", 3'd2, 4'b1000);
    cs = 1'b1;
    step();
    check("ab_end", 3'd0, 4'b0000);

    // edges while deselected are ignored
    pulse(1'b1, 1'b0);
    check("cs1_pe", 3'd0, 4'b0000);
    pulse(1'b0, 1'b1);
    check("cs1_ne", 3'd0, 4'b0000);

    // sclk_ne ignored in GET_ADDR; simultaneous pe+ne counts once
    cs = 1'b0; rw_bit = 1'b0;
    step();
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("ga_ne_ign", 3'd1, 4'b0000);
    pulse(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0);
    check("ga_both_7", 3'd1, 4'b0000);
    pulse(1'b1, 1'b0);
    check("ga_both_8", 3'd2, 4'b1000);
    step();
    check("ga_wget", 3'd5, 4'b0000);
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
    check("ga_dm_we", 3'd6, 4'b0100);
    step();
    check("hold_done", 3'd7, 4'b0000);

    // DONE holds through extra edges while selected
    for (int i = 0; i < 10; i++) begin
      pulse(1'(i % 2 == 0), 1'(i % 3 != 1));
      check("hold", 3'd7, 4'b0000);
    end
    cs = 1'b1;
    step();
    check("hold_end", 3'd0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
